// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits respond one cycle after accept; misses refill one word from memory.
module inst_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ce,
  input  logic                  cpu_stall,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_inst_enable,
  output logic [INST_WIDTH-1:0] cpu_inst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [INST_WIDTH-1:0] mem_data
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [INST_WIDTH-1:0] r_data [LINES];
  logic                  r_inst_enable;
  logic [INST_WIDTH-1:0] r_inst;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_WIDTH-1:0] w_fill_idx;
  logic [TAG_W-1:0]       w_fill_tag;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_fill;
  logic                   w_unused_addr;

  assign w_idx         = cpu_addr[INDEX_WIDTH+1:2];
  assign w_tag         = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  // The refill line is addressed by the latched memory address.
  assign w_fill_idx    = r_mem_addr[INDEX_WIDTH+1:2];
  assign w_fill_tag    = r_mem_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_unused_addr = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_hit) w_next_state = S_REFILL;
      S_REFILL: if (mem_valid)          w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == S_IDLE) && cpu_ce && !cpu_stall;
    w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_fill   = (r_state == S_REFILL) && mem_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_valid             <= '0;
    else if (w_fill) r_valid[w_fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data;
    end
  end

  // A completing refill loads the response even under stall; otherwise stall freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_enable <= 1'b0;
      r_inst        <= '0;
    end else if (w_fill) begin
      r_inst_enable <= 1'b1;
      r_inst        <= mem_data;
    end else if (!cpu_stall) begin
      if (w_accept && w_hit) begin
        r_inst_enable <= 1'b1;
        r_inst        <= r_data[w_idx];
      end else begin
        r_inst_enable <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else if (w_accept && !w_hit) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
    end else if (w_fill) begin
      r_mem_req  <= 1'b0;
    end
  end

  assign cpu_inst_enable = r_inst_enable;
  assign cpu_inst        = r_inst;
  assign mem_req         = r_mem_req;
  assign mem_addr        = r_mem_addr;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: refill, hit, eviction, stall hold and reset abandonment.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic        cpu_stall;
  logic [31:0] cpu_addr;
  logic        cpu_inst_enable;
  logic [31:0] cpu_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  int n_vec = 0;
  int n_err = 0;

  inst_cache #(.ADDR_WIDTH(32), .INST_WIDTH(32), .INDEX_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .cpu_stall(cpu_stall), .cpu_addr(cpu_addr),
    .cpu_inst_enable(cpu_inst_enable), .cpu_inst(cpu_inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: miss on a, then return d on the following cycle.
  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    cpu_ce = 1'b1; cpu_addr = a;
    step();
    cpu_ce = 1'b0;
    step();
    mem_valid = 1'b1; mem_data = d;
    step();
    mem_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_ce = 1'b0; cpu_stall = 1'b0; cpu_addr = '0; mem_valid = 1'b0; mem_data = '0;
    step(); step();
    n_vec++; if (cpu_inst_enable !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", cpu_inst_enable); end
    n_vec++; if (cpu_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", cpu_inst); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_maddr: got %h want 0", mem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_miss_refill();
    cpu_ce = 1'b1; cpu_addr = 32'h0;
    step();
    cpu_ce = 1'b0;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL miss_req: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL miss_maddr: got %h want 0", mem_addr); end
    n_vec++; if (cpu_inst_enable !== 1'b0) begin n_err++; $display("FAIL miss_en: got %b want 0", cpu_inst_enable); end
    step();
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL miss_req_hold: got %b want 1", mem_req); end
    mem_valid = 1'b1; mem_data = 32'h00500093;
    step();
    mem_valid = 1'b0;
    n_vec++; if (cpu_inst_enable !== 1'b1) begin n_err++; $display("FAIL refill_en: got %b want 1", cpu_inst_enable); end
    n_vec++; if (cpu_inst !== 32'h00500093) begin n_err++; $display("FAIL refill_inst: got %h want 00500093", cpu_inst); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL refill_req_drop: got %b want 0", mem_req); end
    step();
    n_vec++; if (cpu_inst_enable !== 1'b0) begin n_err++; $display("FAIL refill_pulse: got %b want 0", cpu_inst_enable); end
  endtask

  task automatic test_hit();
    cpu_ce = 1'b1; cpu_addr = 32'h0;
    step();
    cpu_ce = 1'b0;
    n_vec++; if (cpu_inst_enable !== 1'b1) begin n_err++; $display("FAIL hit_en: got %b want 1", cpu_inst_enable); end
    n_vec++; if (cpu_inst !== 32'h00500093) begin n_err++; $display("FAIL hit_inst: got %h want 00500093", cpu_inst); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL hit_req: got %b want 0", mem_req); end
  endtask

  task automatic test_back_to_back();
    fill(32'h8, 32'h0badc0de);
    cpu_ce = 1'b1; cpu_addr = 32'h0;
    step();
    cpu_addr = 32'h8;
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'h00500093}) begin n_err++; $display("FAIL b2b_first: got %b/%h want 1/00500093", cpu_inst_enable, cpu_inst); end
    step();
    cpu_ce = 1'b0;
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'h0badc0de}) begin n_err++; $display("FAIL b2b_second: got %b/%h want 1/0badc0de", cpu_inst_enable, cpu_inst); end
    step();
    n_vec++; if (cpu_inst_enable !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", cpu_inst_enable); end
  endtask

  task automatic test_evict();
    fill(32'h4, 32'h11111111);
    fill(32'h104, 32'h22222222);
    cpu_ce = 1'b1; cpu_addr = 32'h104;
    step();
    cpu_ce = 1'b0;
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'h22222222}) begin n_err++; $display("FAIL evict_hit104: got %b/%h want 1/22222222", cpu_inst_enable, cpu_inst); end
    cpu_ce = 1'b1; cpu_addr = 32'h4;
    step();
    cpu_ce = 1'b0;
    n_vec++; if (cpu_inst_enable !== 1'b0) begin n_err++; $display("FAIL evict_miss_en: got %b want 0", cpu_inst_enable); end
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin n_err++; $display("FAIL evict_miss_req: got %b/%h want 1/00000004", mem_req, mem_addr); end
    mem_valid = 1'b1; mem_data = 32'h11111111;
    step();
    mem_valid = 1'b0;
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'h11111111}) begin n_err++; $display("FAIL evict_refill: got %b/%h want 1/11111111", cpu_inst_enable, cpu_inst); end
    step();
  endtask

  task automatic test_stall();
    cpu_ce = 1'b1; cpu_addr = 32'h0;
    step();
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'h00500093}) begin n_err++; $display("FAIL stall_hit: got %b/%h want 1/00500093", cpu_inst_enable, cpu_inst); end
    cpu_stall = 1'b1; cpu_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'h00500093}) begin n_err++; $display("FAIL stall_hold%0d: got %b/%h want 1/00500093", i, cpu_inst_enable, cpu_inst); end
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL stall_nolookup%0d: got %b want 0", i, mem_req); end
    end
    cpu_stall = 1'b0; cpu_ce = 1'b0;
    step();
    n_vec++; if ({cpu_inst_enable, mem_req} !== 2'b00) begin n_err++; $display("FAIL stall_release: got %b want 00", {cpu_inst_enable, mem_req}); end
  endtask

  task automatic test_stall_refill();
    cpu_ce = 1'b1; cpu_addr = 32'h10;
    step();
    cpu_ce = 1'b0;
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL sr_req: got %b/%h want 1/00000010", mem_req, mem_addr); end
    cpu_stall = 1'b1; mem_valid = 1'b1; mem_data = 32'haaaa0010;
    step();
    mem_valid = 1'b0;
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'haaaa0010}) begin n_err++; $display("FAIL sr_load: got %b/%h want 1/aaaa0010", cpu_inst_enable, cpu_inst); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sr_req_drop: got %b want 0", mem_req); end
    step();
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'haaaa0010}) begin n_err++; $display("FAIL sr_hold: got %b/%h want 1/aaaa0010", cpu_inst_enable, cpu_inst); end
    cpu_stall = 1'b0;
    step();
    n_vec++; if (cpu_inst_enable !== 1'b0) begin n_err++; $display("FAIL sr_release: got %b want 0", cpu_inst_enable); end
    cpu_ce = 1'b1; cpu_addr = 32'h10;
    step();
    cpu_ce = 1'b0;
    n_vec++; if ({cpu_inst_enable, cpu_inst, mem_req} !== {1'b1, 32'haaaa0010, 1'b0}) begin n_err++; $display("FAIL sr_rehit: got %b/%h/%b want 1/aaaa0010/0", cpu_inst_enable, cpu_inst, mem_req); end
    step();
  endtask

  task automatic test_reset_refill();
    cpu_ce = 1'b1; cpu_addr = 32'hc;
    step();
    cpu_ce = 1'b0;
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'hc}) begin n_err++; $display("FAIL rr_req: got %b/%h want 1/0000000c", mem_req, mem_addr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if ({mem_req, cpu_inst_enable} !== 2'b00) begin n_err++; $display("FAIL rr_abandon: got %b want 00", {mem_req, cpu_inst_enable}); end
    mem_valid = 1'b1; mem_data = 32'hdeadbeef;
    step();
    mem_valid = 1'b0;
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL rr_late_valid: got %b/%h want 0/00000000", cpu_inst_enable, cpu_inst); end
    cpu_ce = 1'b1; cpu_addr = 32'h0;
    step();
    cpu_ce = 1'b0;
    n_vec++; if ({cpu_inst_enable, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0}) begin n_err++; $display("FAIL rr_invalidated: got %b/%b/%h want 0/1/00000000", cpu_inst_enable, mem_req, mem_addr); end
  endtask

  // Continues the refill of 0x0 left open by test_reset_refill.
  task automatic test_addr_change();
    cpu_ce = 1'b1; cpu_addr = 32'h8;
    step();
    n_vec++; if ({mem_req, mem_addr, cpu_inst_enable} !== {1'b1, 32'h0, 1'b0}) begin n_err++; $display("FAIL ac_ignored: got %b/%h/%b want 1/00000000/0", mem_req, mem_addr, cpu_inst_enable); end
    mem_valid = 1'b1; mem_data = 32'h00500093;
    step();
    mem_valid = 1'b0; cpu_ce = 1'b0;
    n_vec++; if ({cpu_inst_enable, cpu_inst} !== {1'b1, 32'h00500093}) begin n_err++; $display("FAIL ac_resp: got %b/%h want 1/00500093", cpu_inst_enable, cpu_inst); end
    step();
    n_vec++; if ({cpu_inst_enable, mem_req} !== 2'b00) begin n_err++; $display("FAIL ac_single: got %b want 00", {cpu_inst_enable, mem_req}); end
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_back_to_back();
    test_evict();
    test_stall();
    test_stall_refill();
    test_reset_refill();
    test_addr_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
